// File: rtl/regfile_rd_arbiter.sv
// Round-robin arbiter sharing one register-file read port between NUM_REQ requesters,
// with a one-entry registered response. Optional macro: ZERO_REG_BYPASS_EN (XZR reads as 0).
module regfile_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rf_rd_addr,
    input  logic [DATA_W-1:0]         rf_rd_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      rsp_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_reg;
    logic [ID_W-1:0]     rsp_id_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ADDR_W-1:0]   last_addr_reg;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic                can_issue;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_en;
    logic [ID_W-1:0]     rr_ptr_next;
    logic [DATA_W-1:0]   load_data;
    int                  scan_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign can_issue = (state_reg == ST_EMPTY) || rsp_ready;

    // Scan from the highest rotated offset down so the entry nearest rr_ptr wins last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr_reg) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req_valid[ID_W'(scan_idx)]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(scan_idx);
            end
        end
    end

    // Gating with rst_n keeps the port quiet while reset is asserted.
    assign grant_en = rst_n && can_issue && grant_vld;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign rf_rd_addr  = grant_en ? addr_arr[grant_idx] : last_addr_reg;
    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_comb begin
        load_data = rf_rd_data;
`ifdef ZERO_REG_BYPASS_EN
        if (rf_rd_addr == ADDR_W'(31)) begin
            load_data = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
            rr_ptr_reg    <= '0;
            last_addr_reg <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (grant_en) begin
                        state_reg <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!grant_en && rsp_ready) begin
                        state_reg <= ST_EMPTY;
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
            // A grant always loads, which also covers the drain-and-refill case without a bubble.
            if (grant_en) begin
                rsp_id_reg    <= grant_idx;
                rsp_data_reg  <= load_data;
                rr_ptr_reg    <= rr_ptr_next;
                last_addr_reg <= rf_rd_addr;
            end
        end
    end

    assign rsp_valid = (state_reg == ST_FULL);
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_regfile_rd_arbiter.sv
// Bench for regfile_rd_arbiter: directed vector table, reset/backpressure sequences,
// and randomized traffic against a behavioural model.
module tb_regfile_rd_arbiter;

    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*5-1:0] req_addr;
    logic [N-1:0]  req_ready;
    logic [4:0]    rf_rd_addr;
    logic [63:0]   rf_rd_data;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [63:0]   rsp_data;
    logic          rsp_ready;

    int n_vec;
    int n_bad;

    // Behavioural model state
    bit          m_valid;
    int          m_id;
    logic [63:0] m_data;
    int          m_ptr;
    logic [4:0]  m_last;

    regfile_rd_arbiter #(.NUM_REQ(N), .ADDR_W(5), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] reg_val(input logic [4:0] a);
        if (a == 5'd31) return 64'hDEAD;
        return {16{a[3:0]}};
    endfunction

    function automatic logic [63:0] exp_data(input logic [4:0] a);
`ifdef ZERO_REG_BYPASS_EN
        if (a == 5'd31) return 64'h0;
`endif
        return reg_val(a);
    endfunction

    always_comb rf_rd_data = reg_val(rf_rd_addr);

    function automatic logic [19:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_id    = 0;
        m_data  = '0;
        m_ptr   = 0;
        m_last  = '0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(
        input  logic [3:0]  v,
        input  logic [19:0] a,
        input  logic        rr,
        output logic [3:0]  o_ready,
        output logic [4:0]  o_rf,
        output logic        o_valid,
        output logic [1:0]  o_id,
        output logic [63:0] o_data,
        output logic [3:0]  e_ready,
        output logic [4:0]  e_rf,
        output logic        e_valid,
        output logic [1:0]  e_id,
        output logic [63:0] e_data
    );
        int g;
        logic [4:0] ga;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        #3;
        g = -1;
        if (!m_valid || rr) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        ga      = (g >= 0) ? a[g*5 +: 5] : m_last;
        e_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        e_rf    = ga;
        o_ready = req_ready;
        o_rf    = rf_rd_addr;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_valid = 1;
            m_id    = g;
            m_data  = exp_data(ga);
            m_ptr   = (g + 1) % N;
            m_last  = ga;
        end else if (rr) begin
            m_valid = 0;
        end
        e_valid = m_valid;
        e_id    = 2'(m_id);
        e_data  = m_data;
        o_valid = rsp_valid;
        o_id    = rsp_id;
        o_data  = rsp_data;
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  v;
        logic [19:0] a;
        logic        rr;
        logic [3:0]  x_ready;
        logic [4:0]  x_rf;
        logic        x_valid;
        logic [1:0]  x_id;
        logic [63:0] x_data;
    } vec_t;

    function automatic vec_t mk(input bit rst, input logic [3:0] v, input logic [19:0] a,
                                input logic rr, input logic [3:0] xr, input int xrf,
                                input logic xv, input int xid, input logic [63:0] xd);
        vec_t t;
        t.rst = rst; t.v = v; t.a = a; t.rr = rr;
        t.x_ready = xr; t.x_rf = 5'(xrf); t.x_valid = xv; t.x_id = 2'(xid); t.x_data = xd;
        return t;
    endfunction

    localparam int NT = 21;
    vec_t tab [NT];

    initial begin
        logic [3:0]  o_ready, e_ready;
        logic [4:0]  o_rf, e_rf;
        logic        o_valid, e_valid;
        logic [1:0]  o_id, e_id;
        logic [63:0] o_data, e_data;
        logic [19:0] fa;
        logic [19:0] za;

        n_vec = 0;
        n_bad = 0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();

        fa = pack4(1, 2, 3, 4);
        za = pack4(31, 2, 3, 4);
        tab[0]  = mk(1, 4'b0000, fa, 1, 4'b0000, 0, 0, 0, 64'h0);
        tab[1]  = mk(0, 4'b0100, pack4(1, 2, 5, 4), 1, 4'b0100, 5, 1, 2, reg_val(5'd5));
        tab[2]  = mk(1, 4'b1111, fa, 1, 4'b0001, 1, 1, 0, reg_val(5'd1));
        tab[3]  = mk(0, 4'b1111, fa, 1, 4'b0010, 2, 1, 1, reg_val(5'd2));
        tab[4]  = mk(0, 4'b1111, fa, 1, 4'b0100, 3, 1, 2, reg_val(5'd3));
        tab[5]  = mk(0, 4'b1111, fa, 1, 4'b1000, 4, 1, 3, reg_val(5'd4));
        tab[6]  = mk(0, 4'b1111, fa, 1, 4'b0001, 1, 1, 0, reg_val(5'd1));
        tab[7]  = mk(0, 4'b1111, fa, 1, 4'b0010, 2, 1, 1, reg_val(5'd2));
        tab[8]  = mk(0, 4'b1111, fa, 1, 4'b0100, 3, 1, 2, reg_val(5'd3));
        tab[9]  = mk(0, 4'b1111, fa, 1, 4'b1000, 4, 1, 3, reg_val(5'd4));
        tab[10] = mk(0, 4'b1111, fa, 0, 4'b0000, 4, 1, 3, reg_val(5'd4));
        tab[11] = mk(0, 4'b1111, fa, 0, 4'b0000, 4, 1, 3, reg_val(5'd4));
        tab[12] = mk(0, 4'b1111, fa, 0, 4'b0000, 4, 1, 3, reg_val(5'd4));
        tab[13] = mk(0, 4'b1111, fa, 1, 4'b0001, 1, 1, 0, reg_val(5'd1));
        tab[14] = mk(0, 4'b0100, fa, 1, 4'b0100, 3, 1, 2, reg_val(5'd3));
        tab[15] = mk(0, 4'b0010, fa, 1, 4'b0010, 2, 1, 1, reg_val(5'd2));
        tab[16] = mk(0, 4'b0000, fa, 1, 4'b0000, 2, 0, 1, reg_val(5'd2));
        tab[17] = mk(0, 4'b0000, fa, 1, 4'b0000, 2, 0, 1, reg_val(5'd2));
        tab[18] = mk(0, 4'b1111, fa, 1, 4'b0100, 3, 1, 2, reg_val(5'd3));
        tab[19] = mk(0, 4'b0001, za, 1, 4'b0001, 31, 1, 0, exp_data(5'd31));
        tab[20] = mk(0, 4'b0000, za, 0, 4'b0000, 31, 1, 0, exp_data(5'd31));

        @(posedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset_req_ready", 64'(req_ready), 64'h0);
        chk("reset_rf_rd_addr", 64'(rf_rd_addr), 64'h0);
        do_reset();

        for (int i = 0; i < NT; i++) begin
            if (tab[i].rst) do_reset();
            step(tab[i].v, tab[i].a, tab[i].rr, o_ready, o_rf, o_valid, o_id, o_data,
                 e_ready, e_rf, e_valid, e_id, e_data);
            $display("vec %0d: valid=%b rr=%b ready=%b rf=%0d rsp_valid=%b id=%0d data=%h",
                     i, tab[i].v, tab[i].rr, o_ready, o_rf, o_valid, o_id, o_data);
            chk($sformatf("vec%0d_req_ready", i), 64'(o_ready), 64'(tab[i].x_ready));
            chk($sformatf("vec%0d_rf_rd_addr", i), 64'(o_rf), 64'(tab[i].x_rf));
            chk($sformatf("vec%0d_rsp_valid", i), 64'(o_valid), 64'(tab[i].x_valid));
            chk($sformatf("vec%0d_rsp_id", i), 64'(o_id), 64'(tab[i].x_id));
            chk($sformatf("vec%0d_rsp_data", i), o_data, tab[i].x_data);
        end

        // Mid-stream asynchronous reset drops the pending response immediately.
        step(4'b0001, pack4(7, 2, 3, 4), 1'b0, o_ready, o_rf, o_valid, o_id, o_data,
             e_ready, e_rf, e_valid, e_id, e_data);
        chk("midrst_pre_valid", 64'(o_valid), 64'h1);
        req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: rsp_valid=%b req_ready=%b rf=%0d", rsp_valid, req_ready, rf_rd_addr);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("midrst_req_ready", 64'(req_ready), 64'h0);
        chk("midrst_rf_rd_addr", 64'(rf_rd_addr), 64'h0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b1;
        model_reset();
        step(4'b0000, fa, 1'b1, o_ready, o_rf, o_valid, o_id, o_data,
             e_ready, e_rf, e_valid, e_id, e_data);
        chk("postrst_req_ready", 64'(o_ready), 64'h0);
        chk("postrst_rsp_valid", 64'(o_valid), 64'h0);
        step(4'b1111, fa, 1'b1, o_ready, o_rf, o_valid, o_id, o_data,
             e_ready, e_rf, e_valid, e_id, e_data);
        $display("post-reset grant: ready=%b id=%0d", o_ready, o_id);
        chk("postrst_first_grant", 64'(o_ready), 64'h1);
        chk("postrst_first_id", 64'(o_id), 64'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  rv;
            logic [19:0] ra;
            logic        rrr;
            rv  = 4'($urandom_range(0, 15));
            ra  = 20'($urandom);
            rrr = ($urandom_range(0, 3) != 0);
            step(rv, ra, rrr, o_ready, o_rf, o_valid, o_id, o_data,
                 e_ready, e_rf, e_valid, e_id, e_data);
            $display("rnd %0d: valid=%b rr=%b ready=%b rf=%0d rsp_valid=%b id=%0d",
                     i, rv, rrr, o_ready, o_rf, o_valid, o_id);
            chk($sformatf("rnd%0d_req_ready", i), 64'(o_ready), 64'(e_ready));
            chk($sformatf("rnd%0d_rf_rd_addr", i), 64'(o_rf), 64'(e_rf));
            chk($sformatf("rnd%0d_rsp_valid", i), 64'(o_valid), 64'(e_valid));
            if (e_valid) begin
                chk($sformatf("rnd%0d_rsp_id", i), 64'(o_id), 64'(e_id));
                chk($sformatf("rnd%0d_rsp_data", i), o_data, e_data);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
